lsu_bus_if: RTL

//  Load/store unit between core execute stage and external data bus (DAD/DDT/MREQ/WRITE/SIZE/ACKD_n).

---
 rtl/lsu_bus_if_pkg.sv | 30 +++
 rtl/lsu_align.sv | 63 ++++++
 rtl/lsu_bus_if.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/lsu_bus_if_pkg.sv
// Shared codes for the load/store bus interface: FSM states, bus SIZE
// encodings and RV32I load/store funct3 values.
package lsu_bus_if_pkg;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'b00,
        LSU_BUS  = 2'b01,
        LSU_DONE = 2'b10
    } lsu_state_t;

    localparam logic [1:0] SZ_W = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_B = 2'b10;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Access width in bus SIZE encoding; funct3[1:0] selects byte/half/word.
    function automatic logic [1:0] size_of(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   size_of = SZ_B;
            2'b01:   size_of = SZ_H;
            default: size_of = SZ_W;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: request legality/alignment check, store lane
// replication, and load lane extraction with sign/zero extension.
module lsu_align
    import lsu_bus_if_pkg::*;
(
    input  logic        i_write,
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_wdata,
    input  logic [2:0]  i_ld_funct3,
    input  logic [1:0]  i_ld_addr_lo,
    input  logic [31:0] i_ld_data,
    output logic        o_ok,
    output logic [1:0]  o_size,
    output logic [31:0] o_wlanes,
    output logic [31:0] o_ld_ext
);

    logic        w_legal;
    logic        w_aligned;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Decide whether the presented request may go to the bus, and steer store lanes.
    always_comb begin
        w_legal   = 1'b0;
        w_aligned = 1'b1;
        o_wlanes  = i_wdata;
        if (i_write)
            w_legal = (i_funct3 == F3_B) || (i_funct3 == F3_H) || (i_funct3 == F3_W);
        else
            w_legal = (i_funct3 == F3_B) || (i_funct3 == F3_H) || (i_funct3 == F3_W) ||
                      (i_funct3 == F3_BU) || (i_funct3 == F3_HU);
        case (i_funct3[1:0])
            2'b00: begin
                o_wlanes = {4{i_wdata[7:0]}};
            end
            2'b01: begin
                w_aligned = ~i_addr_lo[0];
                o_wlanes  = {2{i_wdata[15:0]}};
            end
            default: begin
                w_aligned = (i_addr_lo == 2'b00);
            end
        endcase
        o_ok   = w_legal & w_aligned;
        o_size = size_of(i_funct3);
    end

    // Pick the addressed lane from the bus word and extend it to 32 bits.
    always_comb begin
        w_byte = i_ld_data[{i_ld_addr_lo, 3'b000} +: 8];
        w_half = i_ld_addr_lo[1] ? i_ld_data[31:16] : i_ld_data[15:0];
        case (i_ld_funct3)
            F3_B:    o_ld_ext = {{24{w_byte[7]}}, w_byte};
            F3_BU:   o_ld_ext = {24'h0, w_byte};
            F3_H:    o_ld_ext = {{16{w_half[15]}}, w_half};
            F3_HU:   o_ld_ext = {16'h0, w_half};
            default: o_ld_ext = i_ld_data;
        endcase
    end

endmodule

// File: rtl/lsu_bus_if.sv
// Load/store unit bus interface: accepts one core request, runs a handshaked
// bus cycle (or rejects it as misaligned/illegal), and pulses done once.
module lsu_bus_if
    import lsu_bus_if_pkg::*;
#(
    parameter int TIMEOUT = 256,
    parameter int TO_W    = 9
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic        done,
    output logic [31:0] rdata,
    output logic        misalign,
    output logic        timeout,
    output logic [31:0] DAD,
    inout  wire  [31:0] DDT,
    output logic        MREQ,
    output logic        WRITE,
    output logic [1:0]  SIZE,
    input  logic        ACKD_n
);

    // Last wait-count value before the access is forced to complete.
    localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    lsu_state_t      r_state;
    lsu_state_t      w_next;
    logic [31:0]     r_dad;
    logic [1:0]      r_size;
    logic            r_write;
    logic [2:0]      r_funct3;
    logic [31:0]     r_wlanes;
    logic [TO_W-1:0] r_wait;
    logic [31:0]     r_rdata;
    logic            r_misalign;
    logic            r_timeout;

    logic            w_ok;
    logic [1:0]      w_size;
    logic [31:0]     w_wlanes;
    logic [31:0]     w_ld_ext;
    logic            w_ack;
    logic            w_to_hit;

    lsu_align u_align (
        .i_write      (req_write),
        .i_funct3     (req_funct3),
        .i_addr_lo    (req_addr[1:0]),
        .i_wdata      (req_wdata),
        .i_ld_funct3  (r_funct3),
        .i_ld_addr_lo (r_dad[1:0]),
        .i_ld_data    (DDT),
        .o_ok         (w_ok),
        .o_size       (w_size),
        .o_wlanes     (w_wlanes),
        .o_ld_ext     (w_ld_ext)
    );

    assign w_ack    = ~ACKD_n;
    assign w_to_hit = (TIMEOUT != 0) && (r_wait == TO_LAST);

    // State register; reset abandons any access in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= LSU_IDLE;
        else      r_state <= w_next;
    end

    // Next-state decode: accept or reject in IDLE, finish on ack or timeout, DONE lasts one cycle.
    always_comb begin
        w_next = r_state;
        case (r_state)
            LSU_IDLE: if (req_valid) w_next = w_ok ? LSU_BUS : LSU_DONE;
            LSU_BUS:  if (w_ack || w_to_hit) w_next = LSU_DONE;
            LSU_DONE: w_next = LSU_IDLE;
            default:  w_next = LSU_IDLE;
        endcase
    end

    // Capture request fields at acceptance, count wait cycles, and latch the completion result.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_dad      <= '0;
            r_size     <= SZ_W;
            r_write    <= 1'b0;
            r_funct3   <= '0;
            r_wlanes   <= '0;
            r_wait     <= '0;
            r_rdata    <= '0;
            r_misalign <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_misalign <= 1'b0;
            r_timeout  <= 1'b0;
            case (r_state)
                LSU_IDLE: begin
                    if (req_valid) begin
                        if (w_ok) begin
                            r_dad    <= req_addr;
                            r_size   <= w_size;
                            r_write  <= req_write;
                            r_funct3 <= req_funct3;
                            r_wlanes <= w_wlanes;
                            r_wait   <= '0;
                        end else begin
                            r_misalign <= 1'b1;
                            r_rdata    <= '0;
                        end
                    end
                end
                LSU_BUS: begin
                    // An ack arriving on the final wait cycle takes priority over the timeout.
                    if (w_ack) begin
                        if (!r_write) r_rdata <= w_ld_ext;
                    end else if (w_to_hit) begin
                        r_timeout <= 1'b1;
                        r_rdata   <= '0;
                    end else begin
                        r_wait <= r_wait + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign MREQ     = (r_state == LSU_BUS);
    assign WRITE    = MREQ & r_write;
    assign DAD      = r_dad;
    assign SIZE     = r_size;
    assign done     = (r_state == LSU_DONE);
    assign stall    = req_valid & ~done;
    assign rdata    = r_rdata;
    assign misalign = r_misalign;
    assign timeout  = r_timeout;
    assign DDT      = (MREQ && r_write) ? r_wlanes : 32'hzzzz_zzzz;

endmodule
